// File: rtl/mpd_pkg.sv
// Shared definitions for the parametrised Mealy pattern detector.
// Mode encoding and the default pattern image for WIDTH=4, NPAT=3.
package mpd_pkg;

    typedef enum logic {
        MODE_FRAMED  = 1'b0,
        MODE_SLIDING = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NPAT  = 3;

    // Slot 0 = 0111, slot 1 = 1001, slot 2 = 1110.
    function automatic logic [DEF_NPAT*DEF_WIDTH-1:0] default_pat_init();
        return {4'b1110, 4'b1001, 4'b0111};
    endfunction

endpackage

// File: rtl/mpd_pattern_bank.sv
// Programmable pattern slots with a masked parallel compare.
// The lowest matching enabled slot wins.
module mpd_pattern_bank
    import mpd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NPAT  = 3,
    parameter int IDX_W = 2,
    parameter logic [NPAT*WIDTH-1:0] PAT_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_we,
    input  logic [IDX_W-1:0] pat_idx,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [NPAT-1:0]  pat_en,
    input  logic [WIDTH-1:0] window,
    output logic             hit,
    output logic [IDX_W-1:0] hit_id
);

    logic [WIDTH-1:0] pats [NPAT];
    logic [NPAT-1:0]  eq;

    // Slot registers: reset image, then single-slot writes.
    // Indices with no matching slot are simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NPAT; k++) begin
                pats[k] <= PAT_INIT[k*WIDTH +: WIDTH];
            end
        end else if (pat_we) begin
            for (int k = 0; k < NPAT; k++) begin
                if (pat_idx == IDX_W'(k)) begin
                    pats[k] <= pat_data;
                end
            end
        end
    end

    // Compare every enabled slot against the candidate window.
    always_comb begin
        eq = '0;
        for (int k = 0; k < NPAT; k++) begin
            eq[k] = pat_en[k] && (pats[k] == window);
        end
    end

    // Priority encode: scan downwards so the lowest index lands last.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int k = NPAT - 1; k >= 0; k--) begin
            if (eq[k]) begin
                hit    = 1'b1;
                hit_id = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mealy_pattern_detector_param.sv
// Serial Mealy detector: framed or sliding window against NPAT patterns.
// Holds window history, frame position/fill and the match counter.
module mealy_pattern_detector_param
    import mpd_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NPAT    = 3,
    parameter logic [NPAT*WIDTH-1:0] PAT_INIT =
        (NPAT*WIDTH)'(default_pat_init()),
    parameter int COUNT_W = 8,
    parameter int IDX_W   = (NPAT > 1) ? $clog2(NPAT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in,
    input  logic                     mode,
    input  logic                     restart,
    input  logic                     pat_we,
    input  logic [IDX_W-1:0]         pat_idx,
    input  logic [WIDTH-1:0]         pat_data,
    input  logic [NPAT-1:0]          pat_en,
    input  logic                     cnt_clr,
    output logic                     dec,
    output logic [IDX_W-1:0]         match_id,
    output logic [COUNT_W-1:0]       match_cnt,
    output logic [$clog2(WIDTH)-1:0] frame_pos
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    logic [WIDTH-2:0] history, history_d;
    logic [PW-1:0]    pos, pos_d;
    logic [PW-1:0]    fill, fill_d;
    logic [WIDTH-1:0] window;
    logic             sliding;
    logic             accept;
    logic             window_ready;
    logic             hit;
    logic [IDX_W-1:0] hit_id;

    assign sliding = (mode_e'(mode) == MODE_SLIDING);

    // Oldest bit in the MSB, the bit arriving now in the LSB.
    assign window = {history, in};

    assign accept = in_valid & ~restart;

    assign window_ready = sliding ? (fill == LAST) : (pos == LAST);

    // Zero-latency match flag; forced low while reset is held.
    assign dec = rst_n & accept & window_ready & hit;

    assign match_id = dec ? hit_id : '0;

    assign frame_pos = sliding ? fill : pos;

    mpd_pattern_bank #(
        .WIDTH    (WIDTH),
        .NPAT     (NPAT),
        .IDX_W    (IDX_W),
        .PAT_INIT (PAT_INIT)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .pat_we   (pat_we),
        .pat_idx  (pat_idx),
        .pat_data (pat_data),
        .pat_en   (pat_en),
        .window   (window),
        .hit      (hit),
        .hit_id   (hit_id)
    );

    // Next window state: shift on accepted bits, clear on restart.
    // A framed wrap clears history so frames never overlap.
    always_comb begin
        history_d = history;
        pos_d     = pos;
        fill_d    = fill;
        if (restart) begin
            history_d = '0;
            pos_d     = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            history_d = window[WIDTH-2:0];
            if (sliding) begin
                if (fill != LAST) begin
                    fill_d = fill + 1'b1;
                end
            end else if (pos == LAST) begin
                pos_d     = '0;
                history_d = '0;
            end else begin
                pos_d = pos + 1'b1;
            end
        end
    end

    // Window state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            history <= '0;
            pos     <= '0;
            fill    <= '0;
        end else begin
            history <= history_d;
            pos     <= pos_d;
            fill    <= fill_d;
        end
    end

    // Saturating match counter; an explicit clear beats a new match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (dec && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule
